// File: rtl/pre_if_stage_pkg.sv
// Shared constants and types for the pre-IF stage: bus widths, default
// reset/exception addresses and the request FSM state encoding.
package pre_if_stage_pkg;

    localparam int BR_BUS_WD       = 34;
    localparam int PS_TO_FS_BUS_WD = 34;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;
    localparam logic [31:0] EX_ENTRY_DEFAULT = 32'hbfc00380;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } ps_state_e;

    // Clear the byte offset so the address names a whole word.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pre_if_stage_if.sv
// Address phase of the SRAM-like instruction bus. The fetch stage is the
// master; the memory side only answers with inst_addr_ok.
interface pre_if_stage_if;

    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;

    modport master (
        output inst_req,
        output inst_wr,
        output inst_size,
        output inst_addr,
        input  inst_addr_ok
    );

    modport slave (
        input  inst_req,
        input  inst_wr,
        input  inst_size,
        input  inst_addr,
        output inst_addr_ok
    );

endinterface

// File: rtl/pre_if_redirect_buf.sv
// One-entry redirect holder. Presents the winning redirect (incoming or
// buffered) every cycle and keeps it until the fetch logic consumes it.
// Write-back redirects (exception/eret) always win; a branch can replace a
// buffered branch but never a buffered write-back target.
module pre_if_redirect_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_wb,
    input  logic [31:0] in_target,
    input  logic        consume,
    output logic        sel_valid,
    output logic [31:0] sel_target
);

    logic        buf_valid_reg;
    logic        buf_wb_reg;
    logic [31:0] buf_target_reg;
    logic        take_in;
    logic        sel_wb;

    // Pick between the incoming redirect and the held one
    always_comb begin
        take_in    = in_valid & (in_wb | ~(buf_valid_reg & buf_wb_reg));
        sel_valid  = in_valid | buf_valid_reg;
        sel_target = take_in ? in_target : buf_target_reg;
        sel_wb     = take_in ? in_wb : buf_wb_reg;
    end

    // Capture whatever redirect was not used this cycle
    always_ff @(posedge clk) begin
        if (reset || consume) begin
            buf_valid_reg <= 1'b0;
        end else if (sel_valid) begin
            buf_valid_reg  <= 1'b1;
            buf_wb_reg     <= sel_wb;
            buf_target_reg <= sel_target;
        end
    end

endmodule

// File: rtl/pre_if_stage.sv
// Pre-IF stage: picks the next fetch PC, drives the instruction bus address
// phase and hands accepted PCs to IF one cycle after acceptance, flagging
// requests that a redirect overtook so IF throws their data away.
// Optional build macro PRE_IF_ADEL_EN: misaligned fetch addresses raise an
// address-error instead of being word-aligned.
module pre_if_stage
    import pre_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] EX_ENTRY = EX_ENTRY_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fs_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    input  logic                       ws_ex,
    input  logic                       ws_eret,
    input  logic [31:0]                cp0_epc,
    pre_if_stage_if.master             inst_bus,
    output logic                       ps_to_fs_valid,
    output logic [PS_TO_FS_BUS_WD-1:0] ps_to_fs_bus
);

    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;
    assign {br_stall, br_taken, br_target} = br_bus;

    ps_state_e                  state_reg;
    logic [31:0]                ps_pc_reg;
    logic [31:0]                req_addr_reg;
    logic                       stale_reg;
    logic                       ps_to_fs_valid_reg;
    logic [PS_TO_FS_BUS_WD-1:0] ps_to_fs_bus_reg;
`ifdef PRE_IF_ADEL_EN
    logic                       adel_hold_reg;
`endif

    logic        in_valid;
    logic        in_wb;
    logic [31:0] in_target;
    logic        sel_valid;
    logic [31:0] sel_target;
    logic        consume;
    logic        stale_now;
    logic        can_issue;
    logic        misaligned;
    logic        req_now;
    logic        accept;
    logic [31:0] base_pc;
    logic [31:0] next_raw;
    logic [31:0] next_addr;
    logic [31:0] addr_now;

    // Same-cycle redirect priority: exception, then eret, then branch
    always_comb begin
        in_valid = ws_ex | ws_eret | br_taken;
        in_wb    = ws_ex | ws_eret;
        if (ws_ex) begin
            in_target = EX_ENTRY;
        end else if (ws_eret) begin
            in_target = cp0_epc;
        end else begin
            in_target = br_target;
        end
    end

    pre_if_redirect_buf u_redirect_buf (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_wb      (in_wb),
        .in_target  (in_target),
        .consume    (consume),
        .sel_valid  (sel_valid),
        .sel_target (sel_target)
    );

    // Next fetch address, bus request and redirect consumption
    always_comb begin
        stale_now = stale_reg | in_valid;
        can_issue = fs_allowin & ~br_stall & ~reset;
`ifdef PRE_IF_ADEL_EN
        // After an address error only the exception redirect restarts fetch
        can_issue = can_issue & (~adel_hold_reg | ws_ex);
`endif
        // On acceptance in REQ the sequential PC moves past the delivered
        // word unless a redirect made that word stale
        if (state_reg == REQ && !stale_now) begin
            base_pc = req_addr_reg + 32'd4;
        end else begin
            base_pc = ps_pc_reg;
        end
        next_raw = sel_valid ? sel_target : base_pc;
`ifdef PRE_IF_ADEL_EN
        next_addr  = next_raw;
        misaligned = |next_raw[1:0];
`else
        next_addr  = word_align(next_raw);
        misaligned = 1'b0;
`endif
        if (state_reg == REQ) begin
            req_now  = ~reset;
            addr_now = req_addr_reg;
        end else begin
            req_now  = can_issue & ~misaligned;
            addr_now = next_addr;
        end
        accept = req_now & inst_bus.inst_addr_ok;
        // An issue (or an address-error report) uses up the redirect
        if (state_reg == IDLE) begin
            consume = can_issue;
        end else begin
            consume = accept & can_issue & ~misaligned;
        end
    end

    assign inst_bus.inst_req  = req_now;
    assign inst_bus.inst_wr   = 1'b0;
    assign inst_bus.inst_size = 2'b10;
    assign inst_bus.inst_addr = addr_now;
    assign ps_to_fs_valid     = ps_to_fs_valid_reg;
    assign ps_to_fs_bus       = ps_to_fs_bus_reg;

    // Request FSM with PC tracking and registered hand-off to IF
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= IDLE;
            ps_pc_reg          <= RESET_PC;
            req_addr_reg       <= 32'd0;
            stale_reg          <= 1'b0;
            ps_to_fs_valid_reg <= 1'b0;
            ps_to_fs_bus_reg   <= '0;
`ifdef PRE_IF_ADEL_EN
            adel_hold_reg      <= 1'b0;
`endif
        end else begin
            ps_to_fs_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
`ifdef PRE_IF_ADEL_EN
                    if (ws_ex) begin
                        adel_hold_reg <= 1'b0;
                    end
                    if (can_issue && misaligned) begin
                        ps_to_fs_valid_reg <= 1'b1;
                        ps_to_fs_bus_reg   <= {1'b0, 1'b1, next_addr};
                        adel_hold_reg      <= 1'b1;
                    end
`endif
                    if (req_now) begin
                        if (inst_bus.inst_addr_ok) begin
                            // Accepted in the issue cycle: stay here so the
                            // next word can be issued straight away
                            ps_to_fs_valid_reg <= 1'b1;
                            ps_to_fs_bus_reg   <= {1'b0, 1'b0, next_addr};
                            ps_pc_reg          <= next_addr + 32'd4;
                        end else begin
                            req_addr_reg <= next_addr;
                            stale_reg    <= 1'b0;
                            state_reg    <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (accept) begin
                        ps_to_fs_valid_reg <= 1'b1;
                        ps_to_fs_bus_reg   <= {stale_now, 1'b0, req_addr_reg};
                        ps_pc_reg          <= base_pc;
                        stale_reg          <= 1'b0;
                        if (can_issue && !misaligned) begin
                            req_addr_reg <= next_addr;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (in_valid) begin
                        stale_reg <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pre_if_stage.sv
// Bench for pre_if_stage: directed scenarios against fixed addresses plus a
// randomized run against a fetch-level reference model.
// Honours the PRE_IF_ADEL_EN build macro for the address-error scenario.
module tb_pre_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        fs_allowin;
    logic [33:0] br_bus;
    logic        ws_ex;
    logic        ws_eret;
    logic [31:0] cp0_epc;
    logic        ps_to_fs_valid;
    logic [33:0] ps_to_fs_bus;

    always #5 clk = ~clk;

    pre_if_stage_if bus ();

    pre_if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .fs_allowin     (fs_allowin),
        .br_bus         (br_bus),
        .ws_ex          (ws_ex),
        .ws_eret        (ws_eret),
        .cp0_epc        (cp0_epc),
        .inst_bus       (bus),
        .ps_to_fs_valid (ps_to_fs_valid),
        .ps_to_fs_bus   (ps_to_fs_bus)
    );

    int total = 0;
    int bad   = 0;

    // values sampled from the DUT on the falling edge
    logic        s_req;
    logic        s_valid;
    logic [31:0] s_addr;
    logic [33:0] s_bus;
    // values the reference model expects for the same cycle
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [33:0] e_bus;

    // reference model: sequential PC, one outstanding request, one pending redirect
    bit          m_busy;
    bit          m_stale;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    bit          m_pv;
    bit          m_pwb;
    logic [31:0] m_pt;
    bit          m_dv;
    logic [33:0] m_db;

    task automatic do_reset();
        reset = 1'b1; fs_allowin = 1'b0; br_bus = '0; ws_ex = 1'b0; ws_eret = 1'b0;
        cp0_epc = '0; bus.inst_addr_ok = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_busy = 0; m_stale = 0; m_addr = '0; m_pc = 32'hbfc00000;
        m_pv = 0; m_pwb = 0; m_pt = '0; m_dv = 0; m_db = '0;
    endtask

    // Apply one cycle of inputs, sample the DUT, step the model, cross the edge
    task automatic cycle(input bit allow, input bit stall, input bit taken,
                         input logic [31:0] tgt, input bit ex, input bit eret,
                         input logic [31:0] epc, input bit ok);
        bit          rv, rwb, ev, ewb, disc;
        logic [31:0] rt, et, nxt;
        fs_allowin = allow; br_bus = {stall, taken, tgt}; ws_ex = ex; ws_eret = eret;
        cp0_epc = epc; bus.inst_addr_ok = ok;
        @(negedge clk);
        s_req = bus.inst_req; s_addr = bus.inst_addr;
        s_valid = ps_to_fs_valid; s_bus = ps_to_fs_bus;
        if (s_valid === 1'b1)
            $display("deliver pc=%h adel=%0b discard=%0b", s_bus[31:0], s_bus[32], s_bus[33]);
        e_valid = m_dv; e_bus = m_db;
        rv  = ex | eret | taken;
        rwb = ex | eret;
        rt  = ex ? 32'hbfc00380 : (eret ? epc : tgt);
        if (rv && (rwb || !(m_pv && m_pwb))) begin ev = 1; ewb = rwb; et = rt; end
        else begin ev = m_pv; ewb = m_pwb; et = m_pt; end
        nxt = ev ? et : m_pc;
        nxt = {nxt[31:2], 2'b00};
        e_req  = m_busy | (allow & ~stall);
        e_addr = m_busy ? m_addr : nxt;
        m_dv = 0;
        if (e_req && ok) begin
            disc = m_busy && (m_stale || rv);
            m_dv = 1; m_db = {disc, 1'b0, e_addr};
            if (!disc) m_pc = e_addr + 32'd4;
            if (m_busy) begin
                m_stale = 0;
                if (allow && !stall) begin
                    nxt = ev ? et : m_pc;
                    m_addr = {nxt[31:2], 2'b00};
                    ev = 0;
                end else begin
                    m_busy = 0;
                end
            end else begin
                ev = 0;
            end
        end else if (e_req) begin
            if (!m_busy) begin m_busy = 1; m_addr = nxt; m_stale = 0; ev = 0; end
            else if (rv) m_stale = 1;
        end
        m_pv = ev; m_pwb = ewb; m_pt = et;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 0);  // request at reset PC left hanging
        reset = 1'b1; fs_allowin = 1'b1; bus.inst_addr_ok = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (bus.inst_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", bus.inst_req); end
        total++; if (ps_to_fs_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ps_to_fs_valid); end
        total++; if (ps_to_fs_bus !== 34'd0) begin bad++; $display("FAIL reset_bus got=%h exp=0", ps_to_fs_bus); end
        do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        total++; if (s_addr !== 32'hbfc00000) begin bad++; $display("FAIL reset_first_addr got=%h exp=bfc00000", s_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        total++; if (s_req !== 1'b1 || s_addr !== 32'hbfc00000) begin bad++; $display("FAIL stream_a0 got=%b/%h exp=1/bfc00000", s_req, s_addr); end
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        total++; if (s_req !== 1'b1 || s_addr !== 32'hbfc00004) begin bad++; $display("FAIL stream_a1 got=%b/%h exp=1/bfc00004", s_req, s_addr); end
        total++; if (s_valid !== 1'b1 || s_bus !== {2'b00, 32'hbfc00000}) begin bad++; $display("FAIL stream_d0 got=%b/%h exp=1/0bfc00000", s_valid, s_bus); end
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        total++; if (s_req !== 1'b1 || s_addr !== 32'hbfc00008) begin bad++; $display("FAIL stream_a2 got=%b/%h exp=1/bfc00008", s_req, s_addr); end
        total++; if (s_valid !== 1'b1 || s_bus !== {2'b00, 32'hbfc00004}) begin bad++; $display("FAIL stream_d1 got=%b/%h exp=1/0bfc00004", s_valid, s_bus); end
    endtask

    task automatic test_wait();
        int nv = 0;
        do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0, 0, 0, 0, 0);
            if (s_valid === 1'b1 && s_bus[31:0] === 32'hbfc00004) nv++;
            total++; if (s_req !== 1'b1 || s_addr !== 32'hbfc00004) begin bad++; $display("FAIL wait_hold%0d got=%b/%h exp=1/bfc00004", i, s_req, s_addr); end
        end
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        total++; if (s_req !== 1'b1 || s_addr !== 32'hbfc00004) begin bad++; $display("FAIL wait_accept got=%b/%h exp=1/bfc00004", s_req, s_addr); end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 0, 0);
            if (s_valid === 1'b1 && s_bus[31:0] === 32'hbfc00004) nv++;
        end
        total++; if (nv != 1) begin bad++; $display("FAIL wait_one_valid got=%0d exp=1", nv); end
    endtask

    task automatic test_branch_stale();
        do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 1, 32'hbfc00100, 0, 0, 0, 0);
        total++; if (s_addr !== 32'hbfc00008) begin bad++; $display("FAIL br_hold got=%h exp=bfc00008", s_addr); end
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        total++; if (s_addr !== 32'hbfc00008) begin bad++; $display("FAIL br_accept got=%h exp=bfc00008", s_addr); end
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        total++; if (s_valid !== 1'b1 || s_bus !== {1'b1, 1'b0, 32'hbfc00008}) begin bad++; $display("FAIL br_discard got=%b/%h exp=1/2bfc00008", s_valid, s_bus); end
        total++; if (s_req !== 1'b1 || s_addr !== 32'hbfc00100) begin bad++; $display("FAIL br_target got=%b/%h exp=1/bfc00100", s_req, s_addr); end
    endtask

    task automatic test_ex_priority();
        do_reset();
        cycle(1, 0, 1, 32'hbfc00200, 1, 0, 0, 1);
        total++; if (s_req !== 1'b1 || s_addr !== 32'hbfc00380) begin bad++; $display("FAIL ex_prio got=%b/%h exp=1/bfc00380", s_req, s_addr); end
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        total++; if (s_addr !== 32'hbfc00384) begin bad++; $display("FAIL ex_after got=%h exp=bfc00384", s_addr); end
        total++; if (s_valid !== 1'b1 || s_bus !== {2'b00, 32'hbfc00380}) begin bad++; $display("FAIL ex_deliver got=%b/%h exp=1/0bfc00380", s_valid, s_bus); end
    endtask

    task automatic test_eret_buffer();
        do_reset();
        cycle(0, 0, 0, 0, 0, 1, 32'hbfc00040, 0);
        total++; if (s_req !== 1'b0) begin bad++; $display("FAIL eret_noreq0 got=%b exp=0", s_req); end
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (s_req !== 1'b0) begin bad++; $display("FAIL eret_noreq1 got=%b exp=0", s_req); end
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        total++; if (s_req !== 1'b1 || s_addr !== 32'hbfc00040) begin bad++; $display("FAIL eret_target got=%b/%h exp=1/bfc00040", s_req, s_addr); end
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        total++; if (s_addr !== 32'hbfc00044) begin bad++; $display("FAIL eret_next got=%h exp=bfc00044", s_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        cycle(1, 0, 0, 0, 0, 1, 32'hfffffffc, 1);
        total++; if (s_addr !== 32'hfffffffc) begin bad++; $display("FAIL wrap_top got=%h exp=fffffffc", s_addr); end
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        total++; if (s_addr !== 32'h00000000) begin bad++; $display("FAIL wrap_zero got=%h exp=00000000", s_addr); end
    endtask

`ifdef PRE_IF_ADEL_EN
    task automatic test_adel();
        do_reset();
        cycle(1, 0, 1, 32'hbfc00102, 0, 0, 0, 1);
        total++; if (s_req !== 1'b0) begin bad++; $display("FAIL adel_noreq got=%b exp=0", s_req); end
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        total++; if (s_valid !== 1'b1 || s_bus !== {1'b0, 1'b1, 32'hbfc00102}) begin bad++; $display("FAIL adel_flag got=%b/%h exp=1/1bfc00102", s_valid, s_bus); end
        total++; if (s_req !== 1'b0) begin bad++; $display("FAIL adel_stall got=%b exp=0", s_req); end
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        total++; if (s_req !== 1'b0 || s_valid !== 1'b0) begin bad++; $display("FAIL adel_quiet got=%b/%b exp=0/0", s_req, s_valid); end
        cycle(1, 0, 0, 0, 1, 0, 0, 1);
        total++; if (s_req !== 1'b1 || s_addr !== 32'hbfc00380) begin bad++; $display("FAIL adel_resume got=%b/%h exp=1/bfc00380", s_req, s_addr); end
    endtask
`endif

    task automatic test_random();
        bit          allow, stall, taken, ex, eret, ok;
        logic [31:0] tgt, epc;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            allow = ($urandom % 4) != 0;
            stall = ($urandom % 8) == 0;
            taken = ($urandom % 8) == 0;
            ex    = ($urandom % 32) == 0;
            eret  = ($urandom % 32) == 0;
            ok    = ($urandom % 3) != 0;
            tgt   = $urandom;
            epc   = $urandom & 32'hfffffffc;
`ifdef PRE_IF_ADEL_EN
            tgt   = tgt & 32'hfffffffc;
`endif
            cycle(allow, stall, taken, tgt, ex, eret, epc, ok);
            total++; if (s_req !== e_req) begin bad++; $display("FAIL rnd_req%0d got=%b exp=%b", i, s_req, e_req); end
            if (e_req) begin
                total++; if (s_addr !== e_addr) begin bad++; $display("FAIL rnd_addr%0d got=%h exp=%h", i, s_addr, e_addr); end
            end
            total++; if (s_valid !== e_valid) begin bad++; $display("FAIL rnd_valid%0d got=%b exp=%b", i, s_valid, e_valid); end
            if (e_valid) begin
                total++; if (s_bus !== e_bus) begin bad++; $display("FAIL rnd_bus%0d got=%h exp=%h", i, s_bus, e_bus); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wait();
        test_branch_stale();
        test_ex_priority();
        test_eret_buffer();
        test_wrap();
`ifdef PRE_IF_ADEL_EN
        test_adel();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
